// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 LCD blocks (bus reader and write
// controller): operation modes, the reader state enum, default bus timing
// in system clocks (50 MHz) and small helper functions.
// -----------------------------------------------------------------------------
package lcd_pkg;

  // Operation select values carried with a start request.
  localparam logic [1:0] MODE_STATUS = 2'd0;
  localparam logic [1:0] MODE_DATA   = 2'd1;
  localparam logic [1:0] MODE_POLL   = 2'd2;

  // Default bus timing, in clock cycles at 50 MHz.
  localparam int T_SETUP   = 4;     // RS/RW stable before EN rises (80 ns)
  localparam int T_EN_HIGH = 16;    // EN high time (320 ns)
  localparam int T_HOLD    = 4;     // RS/RW held after EN falls
  localparam int T_GAP     = 8;     // idle bus time between poll reads
  localparam int POLL_MAX  = 2500;  // reads per poll before giving up

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_e;

  // Mode 3 is undefined on the bus and behaves as a status read.
  function automatic logic [1:0] normalize_mode(input logic [1:0] mode);
    return (mode == MODE_DATA || mode == MODE_POLL) ? mode : MODE_STATUS;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_reader_if
// Request/result handshake plus the LCD pins used by the bus reader.
//   start    : request pulse, honoured only while ready=1
//   mode     : operation select sampled with start
//   ready    : reader idle
//   valid    : one-cycle result strobe
//   data     : last byte captured from the LCD bus
//   bf, addr : busy flag / address counter from the last status or poll read
//   timeout  : last poll ended with the busy flag still set
//   lcd_data : LCD data bus, only ever read by the reader
//   lcd_rw, lcd_en, lcd_rs : LCD control pins driven by the reader
// master = requester side, slave = the reader itself.
// -----------------------------------------------------------------------------
interface lcd_bus_reader_if;
  logic       start;
  logic [1:0] mode;
  logic       ready;
  logic       valid;
  logic [7:0] data;
  logic       bf;
  logic [6:0] addr;
  logic       timeout;
  wire  [7:0] lcd_data;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_rs;

  modport master (
    output start, mode,
    input  ready, valid, data, bf, addr, timeout,
    input  lcd_data, lcd_rw, lcd_en, lcd_rs
  );

  modport slave (
    input  start, mode, lcd_data,
    output ready, valid, data, bf, addr, timeout,
    output lcd_rw, lcd_en, lcd_rs
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// -----------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter timing one FSM phase. Loading a length L makes done
// assert during the L-th cycle after the load edge, so a phase entered on
// edge e is left on edge e+L.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : reload the counter (asserted on every state entry)
//   load_value : phase length in cycles, must be >= 1
//   done       : phase has reached its last cycle
// -----------------------------------------------------------------------------
module lcd_phase_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - 1'b1;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// lcd_bus_reader
// Reads the HD44780 over its 8-bit bus: single status reads, single data reads
// (DDRAM/CGRAM byte at the address counter) and busy-flag polling with a read
// limit. Shares the LCD pins with the write controller through external
// muxing and never drives the data bus.
//   clk : 50 MHz system clock
//   rst : asynchronous reset, active-high
//   bus : lcd_bus_reader_if.slave (request/result handshake and LCD pins)
// All outputs are registered from the current state, so the pins trail the
// FSM by one cycle: RS/RW move on the edge after a start is accepted.
// -----------------------------------------------------------------------------
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = T_SETUP,
  parameter int EN_HIGH_CYC = T_EN_HIGH,
  parameter int HOLD_CYC    = T_HOLD,
  parameter int GAP_CYC     = T_GAP,
  parameter int MAX_POLLS   = POLL_MAX
) (
  input logic          clk,
  input logic          rst,
  lcd_bus_reader_if.slave bus
);

  localparam int MAX_PHASE = max_int(max_int(SETUP_CYC, EN_HIGH_CYC),
                                     max_int(HOLD_CYC, GAP_CYC));
  localparam int TW = $clog2(MAX_PHASE + 1);
  localparam int CW = $clog2(MAX_POLLS + 1);

  state_e        state, next_state;
  logic [1:0]    mode_q;
  logic [CW-1:0] poll_cnt;
  logic [CW-1:0] cnt_now;
  logic          bf_now;
  logic          accept;
  logic          capture;
  logic          poll_timeout;
  logic          timer_load;
  logic [TW-1:0] timer_len;
  logic          timer_done;
  logic          in_read;

  lcd_phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_len),
    .done       (timer_done)
  );

  assign accept  = bus.start && bus.ready && (state == ST_IDLE);

  // EN is registered one cycle behind the state, so the first HOLD cycle is
  // the one whose closing edge drops EN: the single capture edge of a read.
  assign capture = (state == ST_HOLD) && bus.lcd_en;

  // Busy flag and read count as they stand once the current read is counted,
  // so the HOLD exit decision is right even for a one-cycle HOLD phase.
  assign bf_now  = capture ? bus.lcd_data[7] : bus.bf;
  assign cnt_now = capture ? poll_cnt + 1'b1 : poll_cnt;

  assign poll_timeout = (mode_q == MODE_POLL) && bf_now &&
                        (cnt_now == CW'(MAX_POLLS));

  assign in_read = (state == ST_SETUP) || (state == ST_EN_HIGH) ||
                   (state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    timer_len  = TW'(1);
    case (state)
      ST_IDLE:    if (accept)     next_state = ST_SETUP;
      ST_SETUP:   if (timer_done) next_state = ST_EN_HIGH;
      ST_EN_HIGH: if (timer_done) next_state = ST_HOLD;
      ST_HOLD: begin
        if (timer_done) begin
          if (mode_q == MODE_POLL && bf_now && !poll_timeout) begin
            next_state = ST_GAP;
          end else begin
            next_state = ST_DONE;
          end
        end
      end
      ST_GAP:     if (timer_done) next_state = ST_SETUP;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase

    case (next_state)
      ST_SETUP:   timer_len = TW'(SETUP_CYC);
      ST_EN_HIGH: timer_len = TW'(EN_HIGH_CYC);
      ST_HOLD:    timer_len = TW'(HOLD_CYC);
      ST_GAP:     timer_len = TW'(GAP_CYC);
      default:    timer_len = TW'(1);
    endcase

    timer_load = (next_state != state);
  end

  // Request context: mode and poll read counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_STATUS;
      poll_cnt <= '0;
    end else if (accept) begin
      mode_q   <= normalize_mode(bus.mode);
      poll_cnt <= '0;
    end else if (capture) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Bus pins and handshake, registered from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready  <= 1'b1;
      bus.valid  <= 1'b0;
      bus.lcd_en <= 1'b0;
      bus.lcd_rw <= 1'b0;
      bus.lcd_rs <= 1'b0;
    end else begin
      bus.ready  <= (state == ST_IDLE) && !accept;
      bus.valid  <= (state == ST_DONE);
      bus.lcd_en <= (state == ST_EN_HIGH);
      bus.lcd_rw <= in_read;
      bus.lcd_rs <= in_read && (mode_q == MODE_DATA);
    end
  end

  // Captured results. Data reads leave the last status untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data    <= 8'h00;
      bus.bf      <= 1'b0;
      bus.addr    <= 7'h00;
      bus.timeout <= 1'b0;
    end else begin
      if (capture) begin
        bus.data <= bus.lcd_data;
        if (mode_q != MODE_DATA) begin
          bus.bf   <= bus.lcd_data[7];
          bus.addr <= bus.lcd_data[6:0];
        end
      end
      if (accept) begin
        bus.timeout <= 1'b0;
      end else if (state == ST_HOLD && timer_done && poll_timeout) begin
        bus.timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_reader
// Self-checking bench for lcd_bus_reader. A bus model answers each EN pulse
// with the next byte from a response queue; a pin monitor measures setup,
// EN-high and hold lengths and RS level; a reference model predicts each
// operation's read count, latency and results from the bus rules.
// -----------------------------------------------------------------------------
module tb_lcd_bus_reader;
  import lcd_pkg::*;

  localparam int TB_POLL_MAX = 5;
  localparam int FIRST_LAT   = 1 + T_SETUP + T_EN_HIGH + T_HOLD;
  localparam int POLL_PERIOD = T_SETUP + T_EN_HIGH + T_HOLD + T_GAP;

  typedef struct {
    int         n;
    logic [7:0] data;
    logic       bf;
    logic [6:0] addr;
    logic       timeout;
    int         latency;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd_bus_reader_if bus ();
  logic [7:0] bus_drive;
  logic [7:0] z_byte = 8'hzz;
  assign bus.lcd_data = bus_drive;

  lcd_bus_reader #(.MAX_POLLS(TB_POLL_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus model and pin monitor ----------------
  logic [7:0] resp_q[$];
  logic [7:0] cur_resp;
  bit         drive_on = 1'b1;
  logic       exp_rs   = 1'b0;
  int         pulses = 0, valid_cnt = 0;
  int         pre = 0, hi = 0, post = 0;
  bit         seen_en = 0, rs_bad = 0;
  logic       en_p = 0, rw_p = 0;

  always @(negedge clk) begin
    if (rst) begin
      pre = 0; hi = 0; post = 0; seen_en = 0; rs_bad = 0;
      en_p = 0; rw_p = 0;
      bus_drive = z_byte;
    end else begin
      if (bus.lcd_en && !en_p) begin
        check("setup_cycles", pre, T_SETUP);
        check("rs_at_en_rise", bus.lcd_rs, exp_rs);
        pulses++;
        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hff;
      end
      if (!bus.lcd_en && en_p) begin
        check("en_high_cycles", hi, T_EN_HIGH);
        seen_en = 1;
      end
      if (!bus.lcd_rw && rw_p) begin
        check("hold_cycles", post, T_HOLD);
        check("rs_stable", rs_bad, 0);
        pre = 0; hi = 0; post = 0; seen_en = 0; rs_bad = 0;
      end
      if (bus.lcd_en) hi++;
      else if (bus.lcd_rw) begin
        if (seen_en) post++;
        else pre++;
      end
      if (bus.lcd_rw && bus.lcd_rs !== exp_rs) rs_bad = 1;
      if (bus.valid) valid_cnt++;
      bus_drive = (drive_on && bus.lcd_en) ? cur_resp : z_byte;
      en_p = bus.lcd_en;
      rw_p = bus.lcd_rw;
    end
  end

  // ---------------- reference model ----------------
  logic       model_bf   = 1'b0;
  logic [6:0] model_addr = 7'h00;

  function automatic exp_t predict(input logic [1:0] mode, input logic [7:0] seq[$]);
    exp_t e;
    int   kind = (mode == 2'd3) ? 0 : int'(mode);
    e.n = 1;
    if (kind == 2) begin
      e.n = TB_POLL_MAX;
      for (int i = 0; i < TB_POLL_MAX; i++) begin
        if (!seq[i][7]) begin
          e.n = i + 1;
          break;
        end
      end
    end
    e.data    = seq[e.n-1];
    e.timeout = (kind == 2) && seq[e.n-1][7];
    if (kind != 1) begin
      model_bf   = seq[e.n-1][7];
      model_addr = seq[e.n-1][6:0];
    end
    e.bf      = model_bf;
    e.addr    = model_addr;
    e.latency = FIRST_LAT + POLL_PERIOD * (e.n - 1);
    return e;
  endfunction

  // ---------------- one operation ----------------
  task automatic run_op(input logic [1:0] mode, input logic [7:0] seq[$],
                        input bit spam, input bit z_watch);
    exp_t e;
    int   p0, v0, lat;
    e      = predict(mode, seq);
    resp_q = seq;
    exp_rs = (mode == MODE_DATA);
    p0 = pulses;
    v0 = valid_cnt;
    @(negedge clk);
    bus.mode  = mode;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("ready_drops", bus.ready, 0);
    check("timeout_cleared", bus.timeout, 0);
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (z_watch) check("lcd_data_z", bus.lcd_data, z_byte);
      if (bus.valid) begin
        lat = c;
        break;
      end
      bus.start = spam && (c >= 2) && (c <= 12);
    end
    bus.start = 1'b0;
    check("latency", lat, e.latency);
    check("data", bus.data, e.data);
    check("bf", bus.bf, e.bf);
    check("addr", bus.addr, e.addr);
    check("timeout", bus.timeout, e.timeout);
    @(posedge clk);
    #1;
    check("valid_one_cycle", bus.valid, 0);
    check("ready_back", bus.ready, 1);
    check("en_pulses", pulses - p0, e.n);
    check("valid_count", valid_cnt - v0, 1);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [7:0] seq[$];
    logic [1:0] m;
    int         k, v0;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    #25;
    check("rst_en", bus.lcd_en, 0);
    check("rst_rw", bus.lcd_rw, 0);
    check("rst_rs", bus.lcd_rs, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_valid", bus.valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_bf", bus.bf, 0);
    check("rst_data", bus.data, 8'h00);
    check("rst_addr", bus.addr, 7'h00);
    check("rst_lcd_data_z", bus.lcd_data, z_byte);
    @(negedge clk);
    rst = 1'b0;

    // Status read, data read, poll clearing on the fourth read.
    seq = '{8'h85};                          run_op(MODE_STATUS, seq, 0, 0);
    seq = '{8'h41};                          run_op(MODE_DATA, seq, 0, 0);
    seq = '{8'h80, 8'h9a, 8'hc3, 8'h20, 8'h11}; run_op(MODE_POLL, seq, 0, 0);
    // Poll timeout: busy flag stuck high for every allowed read.
    seq = '{8'h85, 8'h85, 8'h85, 8'h85, 8'h85}; run_op(MODE_POLL, seq, 0, 0);
    // Mode 3 is a status read; start repeated mid-read is ignored.
    seq = '{8'h7e};                          run_op(2'd3, seq, 1, 0);
    seq = '{8'hd2, 8'h00, 8'h00, 8'h00, 8'h00}; run_op(MODE_POLL, seq, 1, 0);

    // Randomized operations.
    for (int r = 0; r < 10; r++) begin
      m = 2'($urandom_range(0, 3));
      seq.delete();
      if (m == MODE_POLL) begin
        k = $urandom_range(0, TB_POLL_MAX);
        for (int i = 0; i < TB_POLL_MAX; i++)
          seq.push_back({(i < k) ? 1'b1 : 1'b0, 7'($urandom)});
      end else begin
        seq.push_back(8'($urandom));
      end
      run_op(m, seq, 0, 0);
    end

    // Undriven bus: the reader must leave LCD_DATA floating in every state.
    drive_on = 1'b0;
    seq = '{z_byte};
    run_op(MODE_DATA, seq, 0, 1);
    drive_on = 1'b1;

    // Reset while EN is high: pins drop at once, nothing is reported.
    resp_q = '{8'h85};
    exp_rs = 1'b0;
    @(negedge clk);
    bus.mode  = MODE_STATUS;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("en_high_before_rst", bus.lcd_en, 1);
    v0  = valid_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_en", bus.lcd_en, 0);
    check("rst_mid_rw", bus.lcd_rw, 0);
    check("rst_mid_rs", bus.lcd_rs, 0);
    check("rst_mid_ready", bus.ready, 1);
    check("rst_mid_valid", bus.valid, 0);
    check("rst_mid_bf", bus.bf, 0);
    check("rst_mid_addr", bus.addr, 7'h00);
    check("rst_mid_data", bus.data, 8'h00);
    check("rst_mid_timeout", bus.timeout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_q.delete();
    model_bf   = 1'b0;
    model_addr = 7'h00;
    repeat (40) @(posedge clk);
    #1;
    check("no_valid_after_rst", valid_cnt - v0, 0);
    check("idle_after_rst_en", bus.lcd_en, 0);

    // Normal operation resumes after the abort.
    seq = '{8'h33};
    run_op(MODE_STATUS, seq, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Reads the 16x2 HD44780 character LCD over its 8-bit bus. Performs status reads (busy flag plus address counter) and data reads (DDRAM/CGRAM byte at the current address), and polls the busy flag until clear or until a timeout. It sits beside the existing LCD write controller on the same LCD_* pins. External top-level muxing selects which block owns RS/RW/EN. This block never drives LCD_DATA.

## Interface
- T_SETUP, 4: clocks RS/RW are stable before EN rises (80 ns at 50 MHz, at least 40 ns required).
- T_EN_HIGH, 16: clocks EN is held high (320 ns, at least 230 ns required).
- T_HOLD, 4: clocks RS/RW are held after EN falls.
- T_GAP, 8: clocks between successive reads in poll mode.
- POLL_MAX, 2500: maximum reads per poll before timeout.
- iCLK  in  1  50 MHz system clock.
- iRST  in  1  asynchronous reset, active-high.
- iSTART  in  1  request pulse; accepted only when oREADY=1.
- iMODE  in  2  operation select, sampled with iSTART: 0 = status read, 1 = data read, 2 = poll busy, 3 = treated as 0.
- oREADY  out  1  idle, can accept iSTART.
- oVALID  out  1  one-cycle result strobe.
- oDATA  out  8  last byte captured from the bus.
- oBF  out  1  oDATA[7] of the last status read.
- oADDR  out  7  oDATA[6:0] of the last status read.
- oTIMEOUT  out  1  the last poll ended with BF still set.
- LCD_DATA  inout  8  always high-Z from this block; input only.
- LCD_RW  out  1  1 = read.
- LCD_EN  out  1  enable strobe.
- LCD_RS  out  1  0 = status, 1 = data.

## Operation
- States: IDLE, SETUP, EN_HIGH, HOLD, GAP, DONE.
- IDLE: oREADY=1, LCD_RW=0, LCD_EN=0. On iSTART the block latches the mode, clears the poll counter and moves to SETUP.
- SETUP: LCD_RW=1. LCD_RS=1 only for data reads. Lasts T_SETUP cycles, then moves to EN_HIGH.
- EN_HIGH: LCD_EN=1 for T_EN_HIGH cycles. On the final edge of EN_HIGH:
  - EN is deasserted;
  - LCD_DATA is captured into oDATA;
  - for status and poll reads, oBF and oADDR are updated.
- HOLD: LCD_EN=0, RS and RW unchanged, for T_HOLD cycles. Exit depends on mode:
  - single read: go to DONE;
  - poll with BF=0: go to DONE with oTIMEOUT=0;
  - poll with BF=1 and the read count now equal to POLL_MAX: go to DONE with oTIMEOUT=1;
  - poll otherwise: go to GAP.
- GAP: LCD_RW=0 for T_GAP cycles, then back to SETUP. The poll counter increments once per completed read.
- DONE: oVALID=1 for one cycle, then IDLE.
- oTIMEOUT is cleared on every accepted iSTART.
- iSTART outside IDLE is ignored; nothing is queued.
- iRST mid-operation returns to IDLE immediately and drops LCD_EN asynchronously. No partial result is reported.
- LCD_DATA is captured once per read, on a single edge. Data has been stable for at least 160 ns at that edge, so no synchronizer is needed.

## Timing
- Reset values:
  - LCD_EN=0, LCD_RW=0, LCD_RS=0;
  - oREADY=1, oVALID=0, oTIMEOUT=0, oBF=0;
  - oDATA=8'h00, oADDR=7'h00.
- All outputs are registered. RS/RW change on the edge after iSTART is accepted.
- Single read: iSTART sampled at edge 0. Then:
  - EN rises at edge T_SETUP+1 (5);
  - EN falls at edge 21;
  - oVALID is high at edge 1+T_SETUP+T_EN_HIGH+T_HOLD (25);
  - oREADY is high from edge 26.
- Poll read period: T_SETUP+T_EN_HIGH+T_HOLD+T_GAP (32 cycles, 640 ns).
- Poll latency with n reads: 25 + 32·(n−1) cycles to oVALID.
- EN high time is exactly T_EN_HIGH cycles.
- RS/RW are constant from T_SETUP cycles before EN rises until T_HOLD cycles after EN falls.

## Structure
- Package lcd_pkg holds:
  - mode constants MODE_STATUS, MODE_DATA, MODE_POLL;
  - the state enum;
  - default timing constants, shared with the write controller.
- One sub-module, lcd_phase_timer: a loadable down-counter with a done flag, reloaded on each state entry.
- The poll counter is $clog2(POLL_MAX+1) bits wide and lives in the top module.

## Test plan
- Status read: bus model returns 8'h85 -> oVALID at cycle 25, oBF=1, oADDR=7'h05, oDATA=8'h85; RS=0 throughout; EN high exactly 16 cycles.
- Data read: bus returns 8'h41 -> oDATA=8'h41; RS=1 from the SETUP edge through the end of HOLD; oBF and oADDR unchanged from the prior value.
- Poll: BF=1 for 3 reads, then 8'h20 -> oVALID at cycle 25+32·3=121, oBF=0, oADDR=7'h20, oTIMEOUT=0; exactly 4 EN pulses.
- Poll timeout: BF stuck high with POLL_MAX=5 -> 5 EN pulses, oVALID with oTIMEOUT=1, oBF=1.
- iSTART repeated mid-read -> ignored; a single oVALID is produced. iRST asserted during EN_HIGH -> LCD_EN=0 in the same cycle, all outputs at reset values, no oVALID.
- LCD_DATA is never driven by the DUT: the bench drives 8'hZZ and checks it resolves to Z in all states.
